// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared constants, address type, FSM states and modular adder for the QPP turbo blocks
package turbo_pkg;

    localparam int unsigned K_SMALL_DEF = 1056;
    localparam int unsigned K_LARGE_DEF = 6144;

    localparam int unsigned F1_SMALL = 17;
    localparam int unsigned F2_SMALL = 66;
    localparam int unsigned F1_LARGE = 263;
    localparam int unsigned F2_LARGE = 480;

    localparam int unsigned ADDR_W = 13;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        SCATTER,
        SEND
    } state_t;

    // Both operands are already reduced below k, so one conditional subtract suffices.
    function automatic addr_t mod_add(input addr_t a, input addr_t b, input addr_t k);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// rtl/qpp_addr_gen.sv - recursive QPP address generator pi(i); K_LARGE honoured only with TURBO_DEINT_K6144_EN
module qpp_addr_gen
    import turbo_pkg::*;
#(
    parameter int unsigned K_SMALL = K_SMALL_DEF,
    parameter int unsigned K_LARGE = K_LARGE_DEF
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  init,
    input  logic  step,
    input  logic  k_sel,
    output addr_t pi
);

    localparam addr_t K_S  = addr_t'(K_SMALL);
    localparam addr_t G0_S = addr_t'((F1_SMALL + F2_SMALL) % K_SMALL);
    localparam addr_t DG_S = addr_t'((2 * F2_SMALL) % K_SMALL);

    addr_t r_pi;
    addr_t r_g;
    addr_t w_k;
    addr_t w_g0;
    addr_t w_dg;

`ifdef TURBO_DEINT_K6144_EN
    localparam addr_t K_L  = addr_t'(K_LARGE);
    localparam addr_t G0_L = addr_t'((F1_LARGE + F2_LARGE) % K_LARGE);
    localparam addr_t DG_L = addr_t'((2 * F2_LARGE) % K_LARGE);

    assign w_k  = k_sel ? K_L  : K_S;
    assign w_g0 = k_sel ? G0_L : G0_S;
    assign w_dg = k_sel ? DG_L : DG_S;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = k_sel ^ (K_LARGE != 0);
    assign w_k  = K_S;
    assign w_g0 = G0_S;
    assign w_dg = DG_S;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pi <= '0;
            r_g  <= '0;
        end else if (init) begin
            r_pi <= '0;
            r_g  <= w_g0;
        end else if (step) begin
            r_pi <= mod_add(r_pi, r_g, w_k);
            r_g  <= mod_add(r_g, w_dg, w_k);
        end
    end

    assign pi = r_pi;

endmodule

// File: rtl/turbo_deinterleaver.sv
// rtl/turbo_deinterleaver.sv - byte-stream LTE QPP turbo deinterleaver; TURBO_DEINT_K6144_EN adds K=6144 support
module turbo_deinterleaver
    import turbo_pkg::*;
#(
    parameter int unsigned K_SMALL = K_SMALL_DEF,
    parameter int unsigned K_LARGE = K_LARGE_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vld_in,
    input  logic       cbs,
    input  logic [7:0] data_in,
    output logic       rdy_in,
    input  logic       rdy_out,
    output logic       vld_out,
    output logic [7:0] data_out,
    output logic       last_byte
);

`ifdef TURBO_DEINT_K6144_EN
    localparam int unsigned MEM_BITS = K_LARGE;
    localparam int unsigned CNT_W    = 10;
`else
    localparam int unsigned MEM_BITS = K_SMALL;
    localparam int unsigned CNT_W    = 8;
`endif
    localparam int unsigned MEM_AW = CNT_W + 3;

    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(K_SMALL / 8 - 1);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_byte;
    logic [2:0]         r_bit;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [MEM_BITS-1:0] r_mem;

    logic               w_accept;
    logic               w_first;
    logic               w_k_sel;
    logic [CNT_W-1:0]   w_last_idx;
    logic               w_in_last;
    logic               w_out_last;
    logic               w_xfer;
    addr_t              w_pi;
    logic [MEM_AW-1:0]  w_waddr;
    logic [7:0]         w_rdata;

`ifdef TURBO_DEINT_K6144_EN
    localparam logic [CNT_W-1:0] LAST_L = CNT_W'(K_LARGE / 8 - 1);

    logic r_cbs;

    // The block size is frozen by the first byte; later cbs changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cbs <= 1'b0;
        end else if (w_accept && w_first) begin
            r_cbs <= cbs;
        end
    end

    assign w_k_sel    = (w_accept && w_first) ? cbs : r_cbs;
    assign w_last_idx = r_cbs ? LAST_L : LAST_S;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{cbs, w_pi};
    assign w_k_sel      = 1'b0;
    assign w_last_idx   = LAST_S;
`endif

    assign w_accept   = (r_state == RECV) && vld_in;
    assign w_first    = (r_byte_cnt == '0);
    assign w_in_last  = (r_byte_cnt == w_last_idx);
    assign w_out_last = (r_out_cnt == w_last_idx);
    assign w_xfer     = (r_state == SEND) && rdy_out;
    assign w_waddr    = w_pi[MEM_AW-1:0];

    qpp_addr_gen #(
        .K_SMALL (K_SMALL),
        .K_LARGE (K_LARGE)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (w_accept && w_first),
        .step    (r_state == SCATTER),
        .k_sel   (w_k_sel),
        .pi      (w_pi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        rdy_in  = 1'b0;
        vld_out = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = RECV;
            end
            RECV: begin
                rdy_in = 1'b1;
                if (vld_in) begin
                    w_next = SCATTER;
                end
            end
            SCATTER: begin
                if (r_bit == 3'd7) begin
                    w_next = w_in_last ? SEND : RECV;
                end
            end
            SEND: begin
                vld_out = 1'b1;
                if (rdy_out && w_out_last) begin
                    w_next = RECV;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte     <= '0;
            r_bit      <= '0;
            r_byte_cnt <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_byte <= data_in;
                r_bit  <= '0;
            end else if (r_state == SCATTER) begin
                r_bit <= r_bit + 3'd1;
                if (r_bit == 3'd7 && !w_in_last) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end
            if (w_xfer) begin
                if (w_out_last) begin
                    r_out_cnt  <= '0;
                    r_byte_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end
        end
    end

    // pi is a bijection, so every cell is rewritten each block and never needs clearing.
    always_ff @(posedge clk) begin
        if (r_state == SCATTER) begin
            r_mem[w_waddr] <= r_byte[3'd7 - r_bit];
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int b = 0; b < 8; b++) begin
            w_rdata[7-b] = r_mem[{r_out_cnt, 3'(b)}];
        end
    end

    assign data_out  = vld_out ? w_rdata : 8'h00;
    assign last_byte = vld_out && w_out_last;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// tb/tb_turbo_deinterleaver.sv - randomized self-checking bench for turbo_deinterleaver against a direct-formula model
module tb_turbo_deinterleaver;

    localparam int KS = 1056;
    localparam int NB = KS / 8;
`ifdef TURBO_DEINT_K6144_EN
    localparam logic CBS_SMALL_ANY = 1'b0;
`else
    localparam logic CBS_SMALL_ANY = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vld_in;
    logic       cbs;
    logic [7:0] data_in;
    logic       rdy_in;
    logic       rdy_out;
    logic       vld_out;
    logic [7:0] data_out;
    logic       last_byte;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_blk  [2][768];
    logic [7:0] exp_blk [2][768];

    turbo_deinterleaver dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vld_in    (vld_in),
        .cbs       (cbs),
        .data_in   (data_in),
        .rdy_in    (rdy_in),
        .rdy_out   (rdy_out),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .last_byte (last_byte)
    );

    always #5 clk = ~clk;

    task automatic fill_random(input int s, input int nb);
        for (int b = 0; b < nb; b++) begin
            in_blk[s][b] = 8'($urandom);
        end
    endtask

    // out[pi(i)] = in[i], with pi evaluated from its closed form.
    task automatic build_expected(input int s, input int k);
        logic [6143:0] bi;
        logic [6143:0] bo;
        longint f1;
        longint f2;
        longint p;
        bi = '0;
        bo = '0;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        for (int i = 0; i < k; i++) begin
            bi[i] = in_blk[s][i / 8][7 - (i % 8)];
        end
        for (int i = 0; i < k; i++) begin
            p = (f1 * longint'(i) + f2 * longint'(i) * longint'(i)) % longint'(k);
            bo[int'(p)] = bi[i];
        end
        for (int b = 0; b < k / 8; b++) begin
            for (int t = 0; t < 8; t++) begin
                exp_blk[s][b][7-t] = bo[8*b+t];
            end
        end
    endtask

    task automatic send_block(input int s, input int nb, input bit gaps, input logic c,
                              input int start, input bit hold);
        int idx;
        int guard;
        int lat;
        bit v;
        idx = start;
        guard = 0;
        lat = 0;
        rdy_out = 1'b0;
        while (idx < nb && guard < 20000) begin
            @(negedge clk);
            guard++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            vld_in  = v;
            data_in = in_blk[s][idx];
            cbs     = (idx == 0) ? c : 1'($urandom);
            if (v && rdy_in === 1'b1) begin
                idx++;
            end
        end
        checks++;
        if (idx < nb) begin
            errors++;
            $display("FAIL send_timeout accepted %0d want %0d", idx, nb);
        end else begin
            do begin
                @(negedge clk);
                lat++;
                if (hold) begin
                    vld_in  = 1'b1;
                    data_in = 8'($urandom);
                end else begin
                    vld_in = 1'b0;
                end
            end while (vld_out !== 1'b1 && lat < 50);
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL out_latency got %0d negedges want 9", lat);
            end
        end
    endtask

    task automatic recv_block(input int s, input int nb, input int n_take, input bit bp,
                              input int nxt, input logic nxt_cbs);
        int j;
        int guard;
        bit stalled;
        bit r;
        logic [7:0] held;
        logic held_last;
        logic want_last;
        j = 0;
        guard = 0;
        stalled = 0;
        held = 8'h00;
        held_last = 1'b0;
        while (j < n_take && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                checks++;
                if (data_out !== held || last_byte !== held_last || vld_out !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold byte %0d got %h/%b want %h/%b", j, data_out, last_byte, held, held_last);
                end
            end
            r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            rdy_out = r;
            if (vld_out === 1'b1) begin
                if (r) begin
                    want_last = (j == nb - 1);
                    checks++;
                    if (data_out !== exp_blk[s][j] || last_byte !== want_last) begin
                        errors++;
                        $display("FAIL out_byte %0d got %h last %b want %h last %b", j, data_out, last_byte, exp_blk[s][j], want_last);
                    end
                    j++;
                    stalled = 0;
                end else begin
                    held = data_out;
                    held_last = last_byte;
                    stalled = 1;
                end
            end else begin
                stalled = 0;
            end
        end
        checks++;
        if (j < n_take) begin
            errors++;
            $display("FAIL recv_timeout got %0d bytes want %0d", j, n_take);
        end
        if (n_take == nb) begin
            @(negedge clk);
            rdy_out = 1'b0;
            if (nxt >= 0) begin
                vld_in  = 1'b1;
                data_in = in_blk[nxt][0];
                cbs     = nxt_cbs;
            end
            checks++;
            if (rdy_in !== 1'b1 || vld_out !== 1'b0 || last_byte !== 1'b0) begin
                errors++;
                $display("FAIL post_block rdy_in %b vld_out %b last %b want 1 0 0", rdy_in, vld_out, last_byte);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        vld_in  = 1'b0;
        rdy_out = 1'b0;
        cbs     = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy_in !== 1'b0 || vld_out !== 1'b0 || last_byte !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b %h want 000 00", rdy_in, vld_out, last_byte, data_out);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (rdy_in !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge got %b want 0", rdy_in);
        end
        @(negedge clk);
        checks++;
        if (rdy_in !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_edge got %b want 1", rdy_in);
        end
    endtask

    task automatic test_single_bit;
        for (int b = 0; b < NB; b++) begin
            in_blk[0][b]  = 8'h00;
            exp_blk[0][b] = 8'h00;
        end
        in_blk[0][0]  = 8'h40;
        exp_blk[0][10] = 8'h10;
        send_block(0, NB, 1'b0, 1'b0, 0, 1'b0);
        recv_block(0, NB, NB, 1'b0, -1, 1'b0);
    endtask

`ifdef TURBO_DEINT_K6144_EN
    task automatic test_single_bit_k6144;
        for (int b = 0; b < 768; b++) begin
            in_blk[0][b]  = 8'h00;
            exp_blk[0][b] = 8'h00;
        end
        in_blk[0][0]   = 8'h40;
        exp_blk[0][92] = 8'h01;
        send_block(0, 768, 1'b0, 1'b1, 0, 1'b0);
        recv_block(0, 768, 768, 1'b0, -1, 1'b0);
    endtask
`endif

    task automatic test_random_block;
        fill_random(0, NB);
        build_expected(0, KS);
        send_block(0, NB, 1'b0, CBS_SMALL_ANY, 0, 1'b0);
        recv_block(0, NB, NB, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure;
        fill_random(0, NB);
        build_expected(0, KS);
        send_block(0, NB, 1'b1, 1'b0, 0, 1'b0);
        recv_block(0, NB, NB, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_abort;
        int idx;
        int guard;
        fill_random(0, NB);
        idx = 0;
        guard = 0;
        while (idx < 50 && guard < 2000) begin
            @(negedge clk);
            guard++;
            vld_in  = 1'b1;
            data_in = in_blk[0][idx];
            cbs     = 1'b0;
            if (rdy_in === 1'b1) begin
                idx++;
            end
        end
        guard = 0;
        do begin
            @(negedge clk);
            vld_in = 1'b0;
            guard++;
        end while (rdy_in !== 1'b1 && guard < 100);
        reset_n = 1'b0;
        #1;
        checks++;
        if (idx != 50 || guard >= 100 || rdy_in !== 1'b0 || vld_out !== 1'b0 || last_byte !== 1'b0) begin
            errors++;
            $display("FAIL abort_in bytes %0d rdy_in %b vld_out %b last %b want 50 0 0 0", idx, rdy_in, vld_out, last_byte);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_random_block();

        fill_random(0, NB);
        build_expected(0, KS);
        send_block(0, NB, 1'b0, 1'b0, 0, 1'b0);
        recv_block(0, NB, NB - 1, 1'b0, -1, 1'b0);
        @(negedge clk);
        rdy_out = 1'b0;
        checks++;
        if (vld_out !== 1'b1 || last_byte !== 1'b1 || data_out !== exp_blk[0][NB-1]) begin
            errors++;
            $display("FAIL last_stalled got %b %b %h want 1 1 %h", vld_out, last_byte, data_out, exp_blk[0][NB-1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rdy_in !== 1'b0 || vld_out !== 1'b0 || last_byte !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL abort_out got %b%b%b %h want 000 00", rdy_in, vld_out, last_byte, data_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_random_block();
    endtask

    task automatic test_back_to_back;
        fill_random(0, NB);
        fill_random(1, NB);
        build_expected(0, KS);
        build_expected(1, KS);
        send_block(0, NB, 1'b0, 1'b0, 0, 1'b1);
        recv_block(0, NB, NB, 1'b0, 1, 1'b0);
        send_block(1, NB, 1'b0, 1'b0, 1, 1'b0);
        recv_block(1, NB, NB, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_random_block();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
`ifdef TURBO_DEINT_K6144_EN
        test_single_bit_k6144();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
